// File: rtl/trap_peak_capture.sv
`default_nettype none
// ============================================================================
// Module      : trap_peak_capture
// Description : Pulse peak/width capture behind the trapezoidal shaper.
//               A sample at or above THRESHOLD (signed) opens a pulse. The
//               maximum sample and the above-threshold width are tracked
//               until the signal drops below threshold. The completed
//               record goes into a single-entry valid/ready output register.
//               A HOLDOFF-cycle dead time follows every completed pulse.
//               Records that find the output register full are counted as
//               lost (saturating).
// Ports       : clk          - clock, rising edge
//               reset        - synchronous, active-low
//               in_data_i    - signed shaper sample, valid every cycle
//               evt_ready_i  - consumer accepts the record
//               evt_valid_o  - record present
//               evt_amp_o    - signed peak sample of the pulse
//               evt_width_o  - above-threshold sample count (saturating)
//               evt_pileup_o - width reached MAX_WIDTH
//               lost_cnt_o   - records dropped on a full register (saturating)
//               busy_o       - pulse in progress or in dead time
// Revision    : 1.0 - initial release
// ============================================================================
module trap_peak_capture #(
  parameter int DATA_W    = 16,
  parameter int THRESHOLD = 100,
  parameter int MAX_WIDTH = 64,
  parameter int WIDTH_W   = 8,
  parameter int HOLDOFF   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data_i,
  input  logic                     evt_ready_i,
  output logic                     evt_valid_o,
  output logic signed [DATA_W-1:0] evt_amp_o,
  output logic [WIDTH_W-1:0]       evt_width_o,
  output logic                     evt_pileup_o,
  output logic [15:0]              lost_cnt_o,
  output logic                     busy_o
);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic signed [DATA_W-1:0] c_THRESHOLD = DATA_W'(THRESHOLD);
  localparam logic [WIDTH_W:0]         c_MAX_WIDTH = (WIDTH_W + 1)'(MAX_WIDTH);
  localparam logic [WIDTH_W:0]         c_ONE_WIDE  = (WIDTH_W + 1)'(1);
  localparam logic [HOLD_W-1:0]        c_HOLDOFF   = HOLD_W'(HOLDOFF);
  localparam logic [HOLD_W-1:0]        c_HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic [WIDTH_W-1:0]       width_q, width_d;
  logic                     pile_q, pile_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;

  logic                     evt_valid_q;
  logic signed [DATA_W-1:0] evt_amp_q;
  logic [WIDTH_W-1:0]       evt_width_q;
  logic                     evt_pileup_q;
  logic [15:0]              lost_q;
  logic                     busy_q;

  logic                     w_above;
  logic                     w_complete;
  logic                     w_load;
  logic                     w_drop;
  logic [WIDTH_W:0]         w_width_inc;

  // Both operands are signed, so negative undershoot never triggers.
  assign w_above     = (in_data_i >= c_THRESHOLD);
  assign w_width_inc = {1'b0, width_q} + c_ONE_WIDE;

  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    width_d    = width_q;
    pile_d     = pile_q;
    hold_d     = hold_q;
    w_complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_above) begin
          state_d = S_ARMED;
          max_d   = in_data_i;
          width_d = WIDTH_W'(1);
          pile_d  = (c_MAX_WIDTH <= c_ONE_WIDE);
        end
      end
      S_ARMED: begin
        if (w_above) begin
          if (in_data_i > max_q) begin
            max_d = in_data_i;
          end
          // Width sticks at MAX_WIDTH; pile-up latches once it gets there.
          if (w_width_inc >= c_MAX_WIDTH) begin
            width_d = c_MAX_WIDTH[WIDTH_W-1:0];
            pile_d  = 1'b1;
          end else begin
            width_d = w_width_inc[WIDTH_W-1:0];
          end
        end else begin
          w_complete = 1'b1;
          if (HOLDOFF == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            hold_d  = c_HOLDOFF;
          end
        end
      end
      S_HOLD: begin
        // Samples are ignored here; leaving on count 1 gives exactly
        // HOLDOFF cycles of dead time.
        if (hold_q <= c_HOLD_ONE) begin
          state_d = S_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - c_HOLD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A completed record loads if the register is empty or drains this edge.
  assign w_load = w_complete && (!evt_valid_q || evt_ready_i);
  assign w_drop = w_complete && evt_valid_q && !evt_ready_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      max_q        <= '0;
      width_q      <= '0;
      pile_q       <= 1'b0;
      hold_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_amp_q    <= '0;
      evt_width_q  <= '0;
      evt_pileup_q <= 1'b0;
      lost_q       <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      width_q <= width_d;
      pile_q  <= pile_d;
      hold_q  <= hold_d;
      busy_q  <= (state_d != S_IDLE);
      if (w_load) begin
        evt_valid_q  <= 1'b1;
        evt_amp_q    <= max_q;
        evt_width_q  <= width_q;
        evt_pileup_q <= pile_q;
      end else if (evt_valid_q && evt_ready_i) begin
        evt_valid_q <= 1'b0;
      end
      if (w_drop && (lost_q != 16'hFFFF)) begin
        lost_q <= lost_q + 16'd1;
      end
    end
  end

  assign evt_valid_o  = evt_valid_q;
  assign evt_amp_o    = evt_amp_q;
  assign evt_width_o  = evt_width_q;
  assign evt_pileup_o = evt_pileup_q;
  assign lost_cnt_o   = lost_q;
  assign busy_o       = busy_q;

endmodule
`default_nettype wire
